ble_ram_arbiter: RTL and testbench

- Shares the single servant_ram Wishbone port between two requesters: the SERV CPU data/instruction bus and the UART-RX byte stream from the BLE module.
- Received bytes are queued in a small internal FIFO and written one byte per RAM cycle into a ring buffer window of RAM.
- A CPU transaction is never interrupted. Each RX byte is written to exactly one byte lane.
- The FIFO and a sticky overflow flag decouple bursty UART traffic from CPU bus activity.

---
 rtl/ble_ram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ble_ram_arbiter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_ram_arbiter.sv
// Arbitrates the servant_ram Wishbone port between the SERV CPU bus and a BLE UART-RX byte stream.
// Define BLE_ARB_STATUS_EN to add a CPU-visible status register at STATUS_ADR.
module ble_ram_arbiter #(
    parameter logic [31:0] BUF_BASE   = 32'h0000_1000,
    parameter int unsigned BUF_SIZE   = 1024,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned URGENT_LVL = 3,
    parameter logic [31:0] STATUS_ADR = 32'hC000_0010
) (
    input  logic                        i_wb_clk,
    input  logic                        i_wb_rst,
    input  logic                        i_rx_valid,
    input  logic [7:0]                  i_rx_data,
    input  logic [31:0]                 i_cpu_adr,
    input  logic [31:0]                 i_cpu_dat,
    input  logic [3:0]                  i_cpu_sel,
    input  logic                        i_cpu_we,
    input  logic                        i_cpu_cyc,
    output logic [31:0]                 o_cpu_rdt,
    output logic                        o_cpu_ack,
    output logic [31:0]                 o_ram_adr,
    output logic [31:0]                 o_ram_dat,
    output logic [3:0]                  o_ram_sel,
    output logic                        o_ram_we,
    output logic                        o_ram_cyc,
    input  logic [31:0]                 i_ram_rdt,
    input  logic                        i_ram_ack,
    output logic [$clog2(BUF_SIZE)-1:0] o_wr_ptr,
    output logic                        o_overflow
);

    localparam int unsigned PTR_W = $clog2(BUF_SIZE);
    localparam int unsigned FA_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = FA_W + 1;

    typedef enum logic [1:0] {IDLE, CPU, RX} state_t;

    state_t            state;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [FA_W-1:0]   rd_idx;
    logic [FA_W-1:0]   wr_idx;
    logic [LVL_W-1:0]  level;
    logic [PTR_W-1:0]  wr_ptr;
    logic              overflow;

    logic [31:0]       rx_adr;
    logic [31:0]       rx_dat;
    logic [3:0]        rx_sel;
    logic              rx_cyc;

    logic              stat_sel;
    logic              stat_ack;
    logic [31:0]       stat_rdt;

    logic              fifo_empty;
    logic              fifo_full;
    logic              urgent;
    logic              pop;
    logic              push_ok;
    logic              cpu_own;
    logic              is_status;
    logic [7:0]        rx_head;
    logic [31:0]       head_adr;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign urgent     = !fifo_empty && (level >= LVL_W'(URGENT_LVL));
    assign pop        = (state == RX) && i_ram_ack;
    // A full FIFO still accepts a byte when its head leaves on the same edge
    assign push_ok    = i_rx_valid && (!fifo_full || pop);
    assign rx_head    = fifo_mem[rd_idx];
    assign head_adr   = BUF_BASE + 32'(wr_ptr);

`ifdef BLE_ARB_STATUS_EN
    assign is_status = (i_cpu_adr[31:2] == STATUS_ADR[31:2]);
`else
    logic unused_status_adr;
    assign is_status         = 1'b0;
    assign unused_status_adr = ^STATUS_ADR;
`endif

    // CPU owns the RAM bus combinationally; RX drives it from registers
    assign cpu_own   = (state == CPU) && !stat_sel;
    assign o_ram_adr = cpu_own ? i_cpu_adr : rx_adr;
    assign o_ram_dat = cpu_own ? i_cpu_dat : rx_dat;
    assign o_ram_sel = cpu_own ? i_cpu_sel : rx_sel;
    assign o_ram_we  = cpu_own ? i_cpu_we  : rx_cyc;
    assign o_ram_cyc = cpu_own ? i_cpu_cyc : rx_cyc;
    assign o_cpu_rdt = cpu_own ? i_ram_rdt : stat_rdt;
    assign o_cpu_ack = cpu_own ? i_ram_ack : stat_ack;
    assign o_wr_ptr   = wr_ptr;
    assign o_overflow = overflow;

    // FIFO storage carries no reset; its level counter defines validity
    always_ff @(posedge i_wb_clk) begin
        if (push_ok) begin
            fifo_mem[wr_idx] <= i_rx_data;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state    <= IDLE;
            rd_idx   <= '0;
            wr_idx   <= '0;
            level    <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
            rx_adr   <= '0;
            rx_dat   <= '0;
            rx_sel   <= '0;
            rx_cyc   <= 1'b0;
            stat_sel <= 1'b0;
            stat_ack <= 1'b0;
            stat_rdt <= '0;
        end else begin
            if (push_ok) begin
                wr_idx <= wr_idx + FA_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            unique case (state)
                IDLE: begin
                    if (urgent || (!i_cpu_cyc && !fifo_empty)) begin
                        state  <= RX;
                        rx_adr <= head_adr;
                        rx_dat <= {4{rx_head}};
                        rx_sel <= 4'b0001 << head_adr[1:0];
                        rx_cyc <= 1'b1;
                    end else if (i_cpu_cyc) begin
                        state <= CPU;
                        if (is_status) begin
                            stat_sel <= 1'b1;
                            stat_ack <= 1'b1;
                            stat_rdt <= {overflow, 15'b0, 16'(wr_ptr)};
                        end
                    end
                end
                CPU: begin
                    if (stat_sel) begin
                        state    <= IDLE;
                        stat_sel <= 1'b0;
                        stat_ack <= 1'b0;
                        stat_rdt <= '0;
                        if (i_cpu_we) begin
                            overflow <= 1'b0;
                        end
                    end else if (i_ram_ack) begin
                        state <= IDLE;
                    end
                end
                RX: begin
                    if (i_ram_ack) begin
                        state  <= IDLE;
                        rd_idx <= rd_idx + FA_W'(1);
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        rx_adr <= '0;
                        rx_dat <= '0;
                        rx_sel <= '0;
                        rx_cyc <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A dropped byte sets the flag even if a status write clears it this cycle
            if (i_rx_valid && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ble_ram_arbiter.sv
// Self-checking bench for ble_ram_arbiter with a Wishbone RAM model and a ring-buffer scoreboard.
// Status register scenario is compiled in when BLE_ARB_STATUS_EN is defined.
module tb_ble_ram_arbiter;

    localparam logic [31:0] BUF_BASE   = 32'h0000_1000;
    localparam int unsigned BUF_SIZE   = 1024;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } xact_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [31:0] cpu_adr = '0;
    logic [31:0] cpu_dat = '0;
    logic [3:0]  cpu_sel = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_cyc = 1'b0;
    logic [31:0] cpu_rdt;
    logic        cpu_ack;
    logic [31:0] ram_adr;
    logic [31:0] ram_dat;
    logic [3:0]  ram_sel;
    logic        ram_we;
    logic        ram_cyc;
    logic [31:0] ram_rdt = '0;
    logic        ram_ack = 1'b0;
    logic [9:0]  wr_ptr;
    logic        overflow;

    int          tests = 0;
    int          fails = 0;
    int unsigned model_ptr = 0;
    int          ram_delay = 0;
    int          ram_cnt = 0;
    int          ram_cyc_cnt = 0;
    xact_t       rx_q[$];
    logic [31:0] ram_mem [4096];
    logic [31:0] shadow [64];

    ble_ram_arbiter #(
        .BUF_BASE  (BUF_BASE),
        .BUF_SIZE  (BUF_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH),
        .URGENT_LVL(3)
    ) dut (
        .i_wb_clk  (clk),
        .i_wb_rst  (rst),
        .i_rx_valid(rx_valid),
        .i_rx_data (rx_data),
        .i_cpu_adr (cpu_adr),
        .i_cpu_dat (cpu_dat),
        .i_cpu_sel (cpu_sel),
        .i_cpu_we  (cpu_we),
        .i_cpu_cyc (cpu_cyc),
        .o_cpu_rdt (cpu_rdt),
        .o_cpu_ack (cpu_ack),
        .o_ram_adr (ram_adr),
        .o_ram_dat (ram_dat),
        .o_ram_sel (ram_sel),
        .o_ram_we  (ram_we),
        .o_ram_cyc (ram_cyc),
        .i_ram_rdt (ram_rdt),
        .i_ram_ack (ram_ack),
        .o_wr_ptr  (wr_ptr),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    // RAM model: registered one-cycle ack, optional extra wait states
    always @(posedge clk) begin
        ram_ack <= 1'b0;
        if (ram_cyc && !ram_ack) begin
            if (ram_cnt >= ram_delay) begin
                ram_ack <= 1'b1;
                ram_cnt <= 0;
                if (ram_we) begin
                    for (int l = 0; l < 4; l++)
                        if (ram_sel[l]) ram_mem[ram_adr[13:2]][8*l +: 8] <= ram_dat[8*l +: 8];
                end else begin
                    ram_rdt <= ram_mem[ram_adr[13:2]];
                end
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else if (!ram_cyc) begin
            ram_cnt <= 0;
        end
    end

    // Bus monitor: completed ring-buffer writes and RAM-busy cycles
    always @(negedge clk) begin
        if (ram_cyc) ram_cyc_cnt++;
        if (ram_cyc && ram_ack && ram_we && ram_adr >= BUF_BASE && ram_adr < BUF_BASE + BUF_SIZE)
            rx_q.push_back('{adr: ram_adr, dat: ram_dat, sel: ram_sel});
    end

    // Reference: the n-th accepted byte lands at BUF_BASE + (n mod BUF_SIZE), one lane, replicated data
    function automatic xact_t model_write(input logic [7:0] b);
        xact_t e;
        e.adr = BUF_BASE + model_ptr;
        e.sel = 4'(32'd1 << (e.adr % 32'd4));
        e.dat = {b, b, b, b};
        model_ptr = (model_ptr + 1) % BUF_SIZE;
        return e;
    endfunction

    task automatic apply_reset();
        @(posedge clk) #1;
        rst = 1'b1; rx_valid = 1'b0; cpu_cyc = 1'b0; cpu_we = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rx_q.delete();
        model_ptr = 0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(posedge clk) #1;
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic rx_idle();
        @(posedge clk) #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (rx_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic cpu_access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                              input logic we, output logic [31:0] rdt, output bit ok);
        @(posedge clk) #1;
        cpu_adr = adr; cpu_dat = dat; cpu_sel = sel; cpu_we = we; cpu_cyc = 1'b1;
        ok = 1'b0; rdt = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cpu_ack) begin rdt = cpu_rdt; ok = 1'b1; break; end
        end
        @(posedge clk) #1;
        cpu_cyc = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        tests++;
        if ({ram_cyc, ram_we, ram_sel, ram_adr, ram_dat} !== '0) begin
            fails++; $display("FAIL reset_ram_bus: got cyc=%b we=%b sel=%b adr=%h dat=%h, expected all zero",
                              ram_cyc, ram_we, ram_sel, ram_adr, ram_dat);
        end
        tests++;
        if ({cpu_ack, cpu_rdt} !== '0) begin
            fails++; $display("FAIL reset_cpu: got ack=%b rdt=%h, expected 0/0", cpu_ack, cpu_rdt);
        end
        tests++;
        if (wr_ptr !== 10'd0) begin fails++; $display("FAIL reset_wr_ptr: got %0d expected 0", wr_ptr); end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_rx_basic();
        logic [7:0] bytes [3];
        xact_t got, exp;
        bit ok;
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        for (int i = 0; i < 3; i++) rx_send(bytes[i]);
        rx_idle();
        wait_rx(3, 100, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_timeout: got %0d writes expected 3", rx_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                got = rx_q.pop_front(); exp = model_write(bytes[i]); tests++;
                if (got !== exp) begin
                    fails++; $display("FAIL basic_write[%0d]: got %h/%h/%b expected %h/%h/%b",
                                      i, got.adr, got.dat, got.sel, exp.adr, exp.dat, exp.sel);
                end
            end
        end
        repeat (2) @(negedge clk);
        tests++;
        if (wr_ptr !== 10'd3) begin fails++; $display("FAIL basic_wr_ptr: got %0d expected 3", wr_ptr); end
    endtask

    task automatic test_latency();
        int first_cyc = -1, first_ack = -1, first_ptr = -1;
        logic [9:0] p0;
        logic [7:0] b;
        xact_t got, exp;
        bit ok;
        b = 8'($urandom);
        p0 = wr_ptr;
        fork
            begin rx_send(b); rx_idle(); end
            begin
                @(posedge clk);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (first_cyc < 0 && ram_cyc) first_cyc = i;
                    if (first_ack < 0 && ram_ack) first_ack = i;
                    if (first_ptr < 0 && wr_ptr !== p0) first_ptr = i;
                end
            end
        join
        tests++;
        if (first_cyc != 2) begin fails++; $display("FAIL latency_cyc: got cycle %0d expected 2", first_cyc); end
        tests++;
        if (first_ack != 3) begin fails++; $display("FAIL latency_ack: got cycle %0d expected 3", first_ack); end
        tests++;
        if (first_ptr != 4) begin fails++; $display("FAIL latency_ptr: got cycle %0d expected 4", first_ptr); end
        wait_rx(1, 20, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL latency_timeout: got %0d writes expected 1", rx_q.size()); end
        else begin
            got = rx_q.pop_front(); exp = model_write(b); tests++;
            if (got !== exp) begin
                fails++; $display("FAIL latency_write: got %h/%h/%b expected %h/%h/%b",
                                  got.adr, got.dat, got.sel, exp.adr, exp.dat, exp.sel);
            end
        end
    endtask

    task automatic test_cpu_during_rx();
        logic [31:0] rdt;
        int c0, rx_after;
        xact_t got, exp;
        bit ok, wok;
        ram_mem[0] = 32'hDEAD_BEEF;
        c0 = ram_cyc_cnt;
        fork
            begin cpu_access(32'h0, 32'h0, 4'hF, 1'b0, rdt, ok); rx_after = rx_q.size(); end
            begin @(posedge clk); rx_send(8'h55); rx_idle(); end
        join
        tests++;
        if (!ok || rdt !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL cpu_mid_read: got ack=%b rdt=%h expected ack=1 rdt=deadbeef", ok, rdt);
        end
        tests++;
        if (rx_after != 0 || ram_cyc_cnt - c0 != 2) begin
            fails++; $display("FAIL cpu_unbroken: got rx_writes=%0d busy=%0d expected 0 and 2",
                              rx_after, ram_cyc_cnt - c0);
        end
        wait_rx(1, 50, wok);
        tests++;
        if (!wok) begin fails++; $display("FAIL cpu_mid_rx_timeout: got %0d writes expected 1", rx_q.size()); end
        else begin
            got = rx_q.pop_front(); exp = model_write(8'h55); tests++;
            if (got !== exp) begin
                fails++; $display("FAIL cpu_mid_rx_write: got %h/%h/%b expected %h/%h/%b",
                                  got.adr, got.dat, got.sel, exp.adr, exp.dat, exp.sel);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        int rx_mid = -1;
        bit ok = 1'b1, wok;
        xact_t got, exp;
        for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
        fork
            begin
                @(posedge clk) #1;
                cpu_adr = 32'h0; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_cyc = 1'b1;
                for (int k = 0; k < 12; k++) begin
                    bit got_ack = 1'b0;
                    for (int c = 0; c < 100; c++) begin
                        @(negedge clk);
                        if (cpu_ack) begin got_ack = 1'b1; break; end
                    end
                    if (!got_ack) ok = 1'b0;
                    @(posedge clk) #1;
                    if (k < 11) cpu_adr = 32'(4 * (k + 1));
                    else begin rx_mid = rx_q.size(); cpu_cyc = 1'b0; end
                end
            end
            begin
                repeat (3) @(posedge clk);
                for (int i = 0; i < 4; i++) rx_send(bytes[i]);
                rx_idle();
            end
        join
        tests++;
        if (!ok) begin fails++; $display("FAIL b2b_cpu_ack: got a missing ack, expected 12 acks"); end
        tests++;
        if (rx_mid != 2) begin fails++; $display("FAIL b2b_urgent_drain: got %0d writes expected 2", rx_mid); end
        wait_rx(4, 100, wok);
        tests++;
        if (!wok) begin fails++; $display("FAIL b2b_timeout: got %0d writes expected 4", rx_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                got = rx_q.pop_front(); exp = model_write(bytes[i]); tests++;
                if (got !== exp) begin
                    fails++; $display("FAIL b2b_write[%0d]: got %h/%h/%b expected %h/%h/%b",
                                      i, got.adr, got.dat, got.sel, exp.adr, exp.dat, exp.sel);
                end
            end
        end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [6];
        logic [31:0] rdt;
        bit ok, wok;
        xact_t got, exp;
        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
        ram_delay = 8;
        fork
            cpu_access(32'h40, 32'h0, 4'hF, 1'b0, rdt, ok);
            begin
                repeat (2) @(posedge clk);
                for (int i = 0; i < 6; i++) rx_send(bytes[i]);
                rx_idle();
            end
        join
        ram_delay = 0;
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        wait_rx(4, 100, wok);
        tests++;
        if (!wok) begin fails++; $display("FAIL ovf_timeout: got %0d writes expected 4", rx_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                got = rx_q.pop_front(); exp = model_write(bytes[i]); tests++;
                if (got !== exp) begin
                    fails++; $display("FAIL ovf_write[%0d]: got %h/%h/%b expected %h/%h/%b",
                                      i, got.adr, got.dat, got.sel, exp.adr, exp.dat, exp.sel);
                end
            end
        end
        repeat (20) @(negedge clk);
        tests++;
        if (rx_q.size() != 0 || wr_ptr !== 10'(model_ptr)) begin
            fails++; $display("FAIL ovf_dropped: got extra=%0d wr_ptr=%0d expected 0 and %0d",
                              rx_q.size(), wr_ptr, model_ptr);
        end
    endtask

`ifdef BLE_ARB_STATUS_EN
    task automatic test_status();
        logic [31:0] rdt, exp_rdt;
        int c0;
        bit ok;
        c0 = ram_cyc_cnt;
        cpu_access(32'hC000_0010, 32'h0, 4'hF, 1'b0, rdt, ok);
        exp_rdt = {1'b1, 15'b0, 16'(model_ptr)};
        tests++;
        if (!ok || rdt !== exp_rdt) begin
            fails++; $display("FAIL status_read: got ack=%b rdt=%h expected ack=1 rdt=%h", ok, rdt, exp_rdt);
        end
        tests++;
        if (ram_cyc_cnt != c0) begin fails++; $display("FAIL status_no_ram: got %0d RAM cycles expected 0", ram_cyc_cnt - c0); end
        cpu_access(32'hC000_0010, 32'h0, 4'hF, 1'b1, rdt, ok);
        tests++;
        if (!ok || overflow !== 1'b0) begin
            fails++; $display("FAIL status_clear: got ack=%b overflow=%b expected 1/0", ok, overflow);
        end
        cpu_access(32'hC000_0010, 32'h0, 4'hF, 1'b0, rdt, ok);
        exp_rdt = {1'b0, 15'b0, 16'(model_ptr)};
        tests++;
        if (!ok || rdt !== exp_rdt) begin
            fails++; $display("FAIL status_reread: got ack=%b rdt=%h expected ack=1 rdt=%h", ok, rdt, exp_rdt);
        end
    endtask
`endif

    task automatic test_wrap();
        logic [7:0] b, last [2];
        xact_t got, exp;
        bit ok;
        while (model_ptr != BUF_SIZE - 1) begin
            b = 8'($urandom);
            rx_send(b); rx_idle();
            wait_rx(1, 20, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL wrap_fill_timeout at ptr %0d", model_ptr); break; end
            got = rx_q.pop_front(); exp = model_write(b); tests++;
            if (got !== exp) begin
                fails++; $display("FAIL wrap_fill: got %h/%h/%b expected %h/%h/%b",
                                  got.adr, got.dat, got.sel, exp.adr, exp.dat, exp.sel);
            end
        end
        last[0] = 8'hA5; last[1] = 8'h3C;
        rx_send(last[0]); rx_idle();
        repeat (2) @(posedge clk);
        rx_send(last[1]); rx_idle();
        wait_rx(2, 40, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL wrap_timeout: got %0d writes expected 2", rx_q.size()); end
        else begin
            got = rx_q.pop_front(); tests++;
            if (got !== '{adr: 32'h0000_13FF, dat: 32'hA5A5_A5A5, sel: 4'b1000}) begin
                fails++; $display("FAIL wrap_last: got %h/%h/%b expected 000013ff/a5a5a5a5/1000", got.adr, got.dat, got.sel);
            end
            got = rx_q.pop_front(); tests++;
            if (got !== '{adr: 32'h0000_1000, dat: 32'h3C3C_3C3C, sel: 4'b0001}) begin
                fails++; $display("FAIL wrap_first: got %h/%h/%b expected 00001000/3c3c3c3c/0001", got.adr, got.dat, got.sel);
            end
            model_ptr = 1;
        end
        repeat (2) @(negedge clk);
        tests++;
        if (wr_ptr !== 10'd1) begin fails++; $display("FAIL wrap_wr_ptr: got %0d expected 1", wr_ptr); end
    endtask

    task automatic test_random();
        logic [7:0]  sent[$];
        logic [31:0] rdt, dat;
        logic [3:0]  sel;
        int          w;
        bit          ok;
        xact_t       got, exp;
        apply_reset();
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    sent.push_back(8'($urandom));
                    rx_send(sent[$]); rx_idle();
                    repeat (2 + $urandom_range(0, 3)) @(posedge clk);
                end
                1: begin
                    w = $urandom_range(0, 63); dat = $urandom; sel = 4'($urandom_range(1, 15));
                    cpu_access(32'(w * 4), dat, sel, 1'b1, rdt, ok);
                    for (int l = 0; l < 4; l++) if (sel[l]) shadow[w][8*l +: 8] = dat[8*l +: 8];
                    tests++;
                    if (!ok) begin fails++; $display("FAIL rand_cpu_write_ack: no ack at word %0d", w); end
                end
                default: begin
                    w = $urandom_range(0, 63);
                    cpu_access(32'(w * 4), 32'h0, 4'hF, 1'b0, rdt, ok);
                    tests++;
                    if (!ok || rdt !== shadow[w]) begin
                        fails++; $display("FAIL rand_cpu_read: word %0d got ack=%b rdt=%h expected %h", w, ok, rdt, shadow[w]);
                    end
                end
            endcase
        end
        wait_rx(sent.size(), 200, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rand_timeout: got %0d writes expected %0d", rx_q.size(), sent.size()); end
        else begin
            foreach (sent[i]) begin
                got = rx_q.pop_front(); exp = model_write(sent[i]); tests++;
                if (got !== exp) begin
                    fails++; $display("FAIL rand_write[%0d]: got %h/%h/%b expected %h/%h/%b",
                                      i, got.adr, got.dat, got.sel, exp.adr, exp.dat, exp.sel);
                end
            end
        end
        repeat (2) @(negedge clk);
        tests++;
        if (wr_ptr !== 10'(model_ptr) || overflow !== 1'b0) begin
            fails++; $display("FAIL rand_final: got wr_ptr=%0d overflow=%b expected %0d/0", wr_ptr, overflow, model_ptr);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = '0;
        for (int i = 0; i < 64; i++) shadow[i] = '0;
        test_reset();
        test_rx_basic();
        test_latency();
        test_cpu_during_rx();
        shadow[0] = 32'hDEAD_BEEF;
        test_back_to_back();
        test_overflow();
`ifdef BLE_ARB_STATUS_EN
        test_status();
`endif
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
